// File: rtl/upct_if.sv
// Read/update port bundle of the upper PC table.
// The fetch side drives read_*, branch resolution drives update0_*; the table answers on the next cycle.
interface upct_if #(
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int UPPER_PC_WIDTH   = 21
);
  logic                        read_valid;
  logic [LOG_UPCT_ENTRIES-1:0] read_index;
  logic [UPPER_PC_WIDTH-1:0]   read_upper_PC;
  logic                        update0_valid;
  logic [31:0]                 update0_target_full_PC;
  logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index;

  modport master (
    output read_valid, read_index, update0_valid, update0_target_full_PC,
    input  read_upper_PC, update1_upct_index
  );

  modport slave (
    input  read_valid, read_index, update0_valid, update0_target_full_PC,
    output read_upper_PC, update1_upct_index
  );
endinterface

// File: rtl/upct.sv
// Upper PC table: 8-entry fully associative store of branch target upper bits with tree-PLRU.
// Optional macro UPCT_READ_BYPASS_EN forwards a same-cycle allocation to a read of that index.
module upct #(
  parameter int UPCT_ENTRIES     = 8,
  parameter int LOG_UPCT_ENTRIES = 3,
  parameter int UPPER_PC_WIDTH   = 21
) (
  input logic   CLK,
  input logic   RST,
  upct_if.slave bus
);

  typedef logic [UPPER_PC_WIDTH-1:0]   upc_t;
  typedef logic [LOG_UPCT_ENTRIES-1:0] idx_t;
  localparam int LOW_BITS = 32 - UPPER_PC_WIDTH;

  logic [UPCT_ENTRIES-1:0] valid_q, valid_d;
  upc_t                    upc_q [UPCT_ENTRIES];
  upc_t                    upc_d [UPCT_ENTRIES];
  logic [UPCT_ENTRIES-2:0] plru_q, plru_d;
  upc_t                    rd_q, rd_d;
  idx_t                    idx_q, idx_d;

  upc_t upper;
  logic hit;
  idx_t hit_idx;
  logic any_invalid;
  idx_t inv_idx;
  idx_t victim;
  logic [2:0] pair_sel;
  idx_t res_idx;
  logic alloc_en;
  logic unused_low_bits;

  assign upper           = bus.update0_target_full_PC[31:LOW_BITS];
  assign unused_low_bits = ^bus.update0_target_full_PC[LOW_BITS-1:0];

  // Hit search and lowest-invalid pick both look at cycle-start state only.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    any_invalid = 1'b0;
    inv_idx     = '0;
    for (int i = 0; i < UPCT_ENTRIES; i++) begin
      if (valid_q[i] && upc_q[i] == upper) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
    end
    for (int i = UPCT_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_invalid = 1'b1;
        inv_idx     = idx_t'(i);
      end
    end
  end

  always_comb begin
    victim    = '0;
    victim[2] = plru_q[0];
    victim[1] = victim[2] ? plru_q[2] : plru_q[1];
    pair_sel  = 3'd3 + {1'b0, victim[2:1]};
    victim[0] = plru_q[pair_sel];
  end

  always_comb begin
    res_idx  = hit ? hit_idx : (any_invalid ? inv_idx : victim);
    alloc_en = bus.update0_valid && !hit;
  end

  always_comb begin
    valid_d = valid_q;
    upc_d   = upc_q;
    plru_d  = plru_q;
    idx_d   = idx_q;
    if (alloc_en) begin
      valid_d[res_idx] = 1'b1;
      upc_d[res_idx]   = upper;
    end
    if (bus.update0_valid) begin
      idx_d                                  = res_idx;
      plru_d[0]                              = ~res_idx[2];
      plru_d[3'd1 + {2'b00, res_idx[2]}]     = ~res_idx[1];
      plru_d[3'd3 + {1'b0, res_idx[2:1]}]    = ~res_idx[0];
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (bus.read_valid) begin
      rd_d = upc_q[bus.read_index];
`ifdef UPCT_READ_BYPASS_EN
      if (alloc_en && res_idx == bus.read_index) begin
        rd_d = upper;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < UPCT_ENTRIES; i++) begin
        upc_q[i] <= '0;
      end
      plru_q <= '0;
      rd_q   <= '0;
      idx_q  <= '0;
    end else begin
      valid_q <= valid_d;
      upc_q   <= upc_d;
      plru_q  <= plru_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.read_upper_PC      = rd_q;
  assign bus.update1_upct_index = idx_q;

endmodule

// File: tb/tb_upct.sv
// Scoreboard bench for upct: a behavioural table model predicts both output registers every cycle.
// Define UPCT_READ_BYPASS_EN for both RTL and bench to check the forwarding build.
module tb_upct;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  upct_if #(.LOG_UPCT_ENTRIES(3), .UPPER_PC_WIDTH(21)) bus ();

  upct dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid [8];
  logic [20:0] m_upc   [8];
  logic [6:0]  m_plru;
  logic [20:0] m_rd;
  logic [2:0]  m_idx;

  logic [20:0] rd_exp_q  [$];
  logic [2:0]  idx_exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_upc[i]   = '0;
    end
    m_plru = '0;
    m_rd   = '0;
    m_idx  = '0;
    rd_exp_q.delete();
    idx_exp_q.delete();
  endtask

  function automatic logic [2:0] m_victim();
    logic [2:0] v;
    v[2] = m_plru[0];
    if (v[2]) v[1] = m_plru[2];
    else      v[1] = m_plru[1];
    case (v[2:1])
      2'd0:    v[0] = m_plru[3];
      2'd1:    v[0] = m_plru[4];
      2'd2:    v[0] = m_plru[5];
      default: v[0] = m_plru[6];
    endcase
    return v;
  endfunction

  task automatic m_touch(input logic [2:0] i);
    m_plru[0] = ~i[2];
    if (i[2]) m_plru[2] = ~i[1];
    else      m_plru[1] = ~i[1];
    case (i[2:1])
      2'd0:    m_plru[3] = ~i[0];
      2'd1:    m_plru[4] = ~i[0];
      2'd2:    m_plru[5] = ~i[0];
      default: m_plru[6] = ~i[0];
    endcase
  endtask

  // One clock: drive at the falling edge, predict, then compare just after the rising edge.
  task automatic drive(input logic rv, input logic [2:0] ri, input logic uv, input logic [20:0] uu);
    logic       found;
    logic       miss;
    logic [2:0] res;
    @(negedge CLK);
    bus.read_valid             = rv;
    bus.read_index             = ri;
    bus.update0_valid          = uv;
    bus.update0_target_full_PC = {uu, 11'($urandom)};
    found = 1'b0;
    miss  = 1'b0;
    res   = '0;
    if (uv) begin
      for (int i = 0; i < 8; i++)
        if (m_valid[i] && m_upc[i] == uu) begin
          found = 1'b1;
          res   = 3'(i);
        end
      if (!found) begin
        miss = 1'b1;
        res  = m_victim();
        for (int i = 7; i >= 0; i--)
          if (!m_valid[i]) res = 3'(i);
      end
    end
    if (rv) begin
      m_rd = m_upc[ri];
`ifdef UPCT_READ_BYPASS_EN
      if (miss && res == ri) m_rd = uu;
`endif
    end
    if (uv) begin
      m_idx = res;
      m_touch(res);
      if (miss) begin
        m_valid[res] = 1'b1;
        m_upc[res]   = uu;
      end
    end
    rd_exp_q.push_back(m_rd);
    idx_exp_q.push_back(m_idx);
    @(posedge CLK);
    #1;
    chk("read_upper_PC", 32'(bus.read_upper_PC), 32'(rd_exp_q.pop_front()));
    chk("update1_upct_index", 32'(bus.update1_upct_index), 32'(idx_exp_q.pop_front()));
  endtask

  task automatic idle_inputs();
    bus.read_valid             = 1'b0;
    bus.read_index             = '0;
    bus.update0_valid          = 1'b0;
    bus.update0_target_full_PC = '0;
  endtask

  task automatic check_unique();
    int dups;
    dups = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (dut.valid_q[i] && dut.valid_q[j] && dut.upc_q[i] == dut.upc_q[j]) dups++;
    chk("unique_upper", 32'(dups), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_upd;
    logic       rv, uv;
    logic [2:0] ri, v;
    idle_inputs();
    m_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_read_upper_PC", 32'(bus.read_upper_PC), 32'd0);
    chk("rst_update_index", 32'(bus.update1_upct_index), 32'd0);

    drive(1'b1, 3'd5, 1'b0, '0);

    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 3'd0, 1'b1, 21'(k + 1));
      chk("fill_index", 32'(bus.update1_upct_index), 32'(k));
    end
    drive(1'b1, 3'd3, 1'b0, '0);
    chk("fill_read3", 32'(bus.read_upper_PC), 32'h4);

    drive(1'b0, 3'd0, 1'b1, 21'd3);
    chk("hit_u3", 32'(bus.update1_upct_index), 32'd2);
    drive(1'b0, 3'd0, 1'b1, 21'd9);
    chk("plru_victim", 32'(bus.update1_upct_index), 32'd4);
    drive(1'b1, 3'd4, 1'b0, '0);
    chk("read_victim", 32'(bus.read_upper_PC), 32'h9);

    // Same-cycle read of the entry that the next miss allocates.
    v = m_victim();
    drive(1'b1, v, 1'b1, 21'd10);
    chk("same_cycle_alloc", 32'(bus.update1_upct_index), 32'(v));

    drive(1'b0, 3'd0, 1'b1, 21'd11);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_index", 32'(bus.update1_upct_index), 32'd0);
    chk("async_rst_read", 32'(bus.read_upper_PC), 32'd0);
    chk("async_rst_valid", 32'(dut.valid_q), 32'd0);
    idle_inputs();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m_reset();
    drive(1'b0, 3'd0, 1'b1, 21'd7);
    chk("post_rst_u7", 32'(bus.update1_upct_index), 32'd0);

    n_upd = 0;
    while (n_upd < 10000) begin
      uv = ($urandom_range(0, 3) != 0);
      rv = $urandom_range(0, 1) == 1;
      ri = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rv = 1'b1;
        ri = m_idx;
      end
      drive(rv, ri, uv, 21'($urandom_range(1, 14)));
      if (uv) n_upd++;
      if (n_upd % 500 == 0) check_unique();
    end
    check_unique();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
